// File: rtl/mod5_pointer_unit.sv
// Mod-5 arithmetic unit: combinational residue outputs plus a registered wrap-around pointer.
// Optional feature: define MOD5_SUB_EN to add the DIFF output ((A - B) mod 5).
`timescale 1ns/1ps
module mod5_pointer_unit #(
    parameter logic [2:0] PTR_INIT = 3'd0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [2:0] A,
    input  logic [2:0] B,
    input  logic       INC,
    input  logic       DEC,
    output logic [2:0] RED,
    output logic [2:0] SUM,
    output logic [2:0] NEXT,
    output logic [2:0] PREV,
    output logic [2:0] PTR
`ifdef MOD5_SUB_EN
    ,
    output logic [2:0] DIFF
`endif
);

    // Reduces 0..15 to its residue; the carry bit of a 3-bit sum is kept as bit 3.
    function automatic logic [2:0] mod5_reduce(input logic [3:0] v);
        logic [2:0] r;
        case (v)
            4'd0, 4'd5, 4'd10, 4'd15: r = 3'd0;
            4'd1, 4'd6, 4'd11:        r = 3'd1;
            4'd2, 4'd7, 4'd12:        r = 3'd2;
            4'd3, 4'd8, 4'd13:        r = 3'd3;
            4'd4, 4'd9, 4'd14:        r = 3'd4;
            default:                  r = 3'd0;
        endcase
        return r;
    endfunction

    // Unreachable codes 5..7 fall back to 0 so a corrupted pointer self-recovers.
    function automatic logic [2:0] mod5_next(input logic [2:0] r);
        logic [2:0] n;
        case (r)
            3'd0:    n = 3'd1;
            3'd1:    n = 3'd2;
            3'd2:    n = 3'd3;
            3'd3:    n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic [2:0] mod5_prev(input logic [2:0] r);
        logic [2:0] p;
        case (r)
            3'd0:    p = 3'd4;
            3'd1:    p = 3'd0;
            3'd2:    p = 3'd1;
            3'd3:    p = 3'd2;
            3'd4:    p = 3'd3;
            default: p = 3'd0;
        endcase
        return p;
    endfunction

    logic [2:0] red_a_s;
    logic [2:0] ptr_q;
    logic [2:0] ptr_d;

    // Combinational residue outputs derived from A and B.
    always_comb begin
        red_a_s = mod5_reduce({1'b0, A});
        RED     = red_a_s;
        SUM     = mod5_reduce({1'b0, A} + {1'b0, B});
        NEXT    = mod5_next(red_a_s);
        PREV    = mod5_prev(red_a_s);
    end

`ifdef MOD5_SUB_EN
    logic [2:0] red_b_s;

    // Difference is formed as RED(A) + 5 - RED(B), always within 1..9 before reduction.
    always_comb begin
        red_b_s = mod5_reduce({1'b0, B});
        DIFF    = mod5_reduce({1'b0, red_a_s} + 4'd5 - {1'b0, red_b_s});
    end
`endif

    // Pointer next state; simultaneous or absent requests hold.
    always_comb begin
        ptr_d = ptr_q;
        case ({INC, DEC})
            2'b10:   ptr_d = mod5_next(ptr_q);
            2'b01:   ptr_d = mod5_prev(ptr_q);
            default: ptr_d = ptr_q;
        endcase
    end

    // Pointer register with asynchronous reset to PTR_INIT.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ptr_q <= PTR_INIT;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign PTR = ptr_q;

endmodule

// File: tb/tb_mod5_pointer_unit.sv
// Self-checking bench for mod5_pointer_unit: directed sweeps plus randomized traffic
// against an arithmetic mod-5 reference model.
`timescale 1ns/1ps
module tb_mod5_pointer_unit;

    logic       CLK;
    logic       RESET;
    logic [2:0] A;
    logic [2:0] B;
    logic       INC;
    logic       DEC;
    logic [2:0] RED;
    logic [2:0] SUM;
    logic [2:0] NEXT;
    logic [2:0] PREV;
    logic [2:0] PTR;
`ifdef MOD5_SUB_EN
    logic [2:0] DIFF;
`endif

    int pass_cnt;
    int total_cnt;
    int ptr_m;

    mod5_pointer_unit #(.PTR_INIT(3'd0)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .A     (A),
        .B     (B),
        .INC   (INC),
        .DEC   (DEC),
        .RED   (RED),
        .SUM   (SUM),
        .NEXT  (NEXT),
        .PREV  (PREV),
        .PTR   (PTR)
`ifdef MOD5_SUB_EN
        ,
        .DIFF  (DIFF)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic test_reset();
        RESET = 1'b1; INC = 1'b1; DEC = 1'b0; A = 3'd0; B = 3'd0;
        #1;
        total_cnt++;
        if (PTR !== 3'd0) $display("FAIL reset_async: PTR=%0d expected 0", PTR);
        else pass_cnt++;
        repeat (2) @(posedge CLK);
        #1;
        total_cnt++;
        if (PTR !== 3'd0) $display("FAIL reset_hold_inc: PTR=%0d expected 0", PTR);
        else pass_cnt++;
        @(negedge CLK);
        RESET = 1'b0; INC = 1'b0;
        ptr_m = 0;
    endtask

    task automatic test_red_next_prev();
        int exp_red [8] = '{0, 1, 2, 3, 4, 0, 1, 2};
        int exp_next[8] = '{1, 2, 3, 4, 0, 1, 2, 3};
        int exp_prev[8] = '{4, 0, 1, 2, 3, 4, 0, 1};
        for (int i = 0; i < 8; i++) begin
            A = 3'(i);
            #1;
            total_cnt++;
            if (RED !== 3'(exp_red[i])) $display("FAIL sweep_red A=%0d: RED=%0d expected %0d", i, RED, exp_red[i]);
            else pass_cnt++;
            total_cnt++;
            if (NEXT !== 3'(exp_next[i])) $display("FAIL sweep_next A=%0d: NEXT=%0d expected %0d", i, NEXT, exp_next[i]);
            else pass_cnt++;
            total_cnt++;
            if (PREV !== 3'(exp_prev[i])) $display("FAIL sweep_prev A=%0d: PREV=%0d expected %0d", i, PREV, exp_prev[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_sum();
        int va[5]  = '{1, 5, 0, 1, 7};
        int vb[5]  = '{1, 1, 4, 3, 1};
        int exp[5] = '{2, 1, 4, 4, 3};
        for (int i = 0; i < 5; i++) begin
            A = 3'(va[i]); B = 3'(vb[i]);
            #1;
            total_cnt++;
            if (SUM !== 3'(exp[i])) $display("FAIL sum A=%0d B=%0d: SUM=%0d expected %0d", va[i], vb[i], SUM, exp[i]);
            else pass_cnt++;
        end
    endtask

`ifdef MOD5_SUB_EN
    task automatic test_diff();
        int va[5]  = '{1, 5, 0, 1, 7};
        int vb[5]  = '{1, 1, 3, 3, 1};
        int exp[5] = '{0, 4, 2, 3, 1};
        for (int i = 0; i < 5; i++) begin
            A = 3'(va[i]); B = 3'(vb[i]);
            #1;
            total_cnt++;
            if (DIFF !== 3'(exp[i])) $display("FAIL diff A=%0d B=%0d: DIFF=%0d expected %0d", va[i], vb[i], DIFF, exp[i]);
            else pass_cnt++;
        end
    endtask
`endif

    task automatic test_exhaustive_comb();
        int ra;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                A = 3'(a); B = 3'(b);
                #1;
                ra = a % 5;
                total_cnt++;
                if (SUM !== 3'((a + b) % 5) || RED !== 3'(ra) || NEXT !== 3'((ra + 1) % 5) ||
                    PREV !== 3'((ra + 4) % 5))
                    $display("FAIL exhaustive A=%0d B=%0d: RED=%0d SUM=%0d NEXT=%0d PREV=%0d expected %0d %0d %0d %0d",
                             a, b, RED, SUM, NEXT, PREV, ra, (a + b) % 5, (ra + 1) % 5, (ra + 4) % 5);
                else pass_cnt++;
`ifdef MOD5_SUB_EN
                total_cnt++;
                if (DIFF !== 3'((ra - (b % 5) + 5) % 5))
                    $display("FAIL exhaustive_diff A=%0d B=%0d: DIFF=%0d expected %0d", a, b, DIFF, (ra - (b % 5) + 5) % 5);
                else pass_cnt++;
`endif
            end
        end
    endtask

    task automatic test_ptr_sequence();
        int inc_exp[6] = '{1, 2, 3, 4, 0, 1};
        int dec_exp[2] = '{0, 4};
        INC = 1'b1; DEC = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge CLK);
            #1;
            total_cnt++;
            if (PTR !== 3'(inc_exp[i])) $display("FAIL ptr_inc step%0d: PTR=%0d expected %0d", i, PTR, inc_exp[i]);
            else pass_cnt++;
        end
        INC = 1'b0; DEC = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            total_cnt++;
            if (PTR !== 3'(dec_exp[i])) $display("FAIL ptr_dec step%0d: PTR=%0d expected %0d", i, PTR, dec_exp[i]);
            else pass_cnt++;
        end
        ptr_m = 4;
    endtask

    task automatic test_hold_and_reset();
        INC = 1'b0; DEC = 1'b1;
        @(posedge CLK);
        #1;
        total_cnt++;
        if (PTR !== 3'd3) $display("FAIL ptr_to3: PTR=%0d expected 3", PTR);
        else pass_cnt++;
        INC = 1'b1; DEC = 1'b1;
        @(posedge CLK);
        #1;
        total_cnt++;
        if (PTR !== 3'd3) $display("FAIL ptr_both_hold: PTR=%0d expected 3", PTR);
        else pass_cnt++;
        INC = 1'b1; DEC = 1'b0; A = 3'd7; B = 3'd6;
        #2;
        RESET = 1'b1;
        #1;
        total_cnt++;
        if (PTR !== 3'd0) $display("FAIL reset_midcycle: PTR=%0d expected 0", PTR);
        else pass_cnt++;
        total_cnt++;
        if (RED !== 3'd2 || SUM !== 3'd3) $display("FAIL comb_during_reset: RED=%0d SUM=%0d expected 2 3", RED, SUM);
        else pass_cnt++;
        repeat (2) @(posedge CLK);
        #1;
        total_cnt++;
        if (PTR !== 3'd0) $display("FAIL reset_held: PTR=%0d expected 0", PTR);
        else pass_cnt++;
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        total_cnt++;
        if (PTR !== 3'd1) $display("FAIL first_edge_after_reset: PTR=%0d expected 1", PTR);
        else pass_cnt++;
        ptr_m = 1;
    endtask

    task automatic test_random();
        int a, b, ra, rb;
        for (int n = 0; n < 400; n++) begin
            a = int'($urandom_range(0, 7));
            b = int'($urandom_range(0, 7));
            A = 3'(a); B = 3'(b);
            INC = 1'($urandom_range(0, 1));
            DEC = 1'($urandom_range(0, 1));
            #1;
            ra = a % 5;
            rb = b % 5;
            total_cnt++;
            if (RED !== 3'(ra) || SUM !== 3'((a + b) % 5) || NEXT !== 3'((ra + 1) % 5) || PREV !== 3'((ra + 4) % 5))
                $display("FAIL random_comb A=%0d B=%0d: RED=%0d SUM=%0d NEXT=%0d PREV=%0d", a, b, RED, SUM, NEXT, PREV);
            else pass_cnt++;
`ifdef MOD5_SUB_EN
            total_cnt++;
            if (DIFF !== 3'((ra - rb + 5) % 5))
                $display("FAIL random_diff A=%0d B=%0d: DIFF=%0d expected %0d", a, b, DIFF, (ra - rb + 5) % 5);
            else pass_cnt++;
`endif
            total_cnt++;
            if (RED > 3'd4 || SUM > 3'd4 || NEXT > 3'd4 || PREV > 3'd4)
                $display("FAIL random_range A=%0d B=%0d: output above 4 (rb=%0d)", a, b, rb);
            else pass_cnt++;
            @(posedge CLK);
            if (INC && !DEC) ptr_m = (ptr_m + 1) % 5;
            else if (DEC && !INC) ptr_m = (ptr_m + 4) % 5;
            #1;
            total_cnt++;
            if (PTR !== 3'(ptr_m)) $display("FAIL random_ptr cycle%0d: PTR=%0d expected %0d", n, PTR, ptr_m);
            else pass_cnt++;
        end
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        ptr_m     = 0;
        test_reset();
        test_red_next_prev();
        test_sum();
`ifdef MOD5_SUB_EN
        test_diff();
`endif
        test_exhaustive_comb();
        test_ptr_sequence();
        test_hold_and_reset();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
